// File: rtl/ir_queue.sv
// ir_queue -- instruction queue with head decode for a Gumnut-style core.
//
// A circular buffer of DEPTH 18-bit instruction words. The head entry is
// decoded combinationally into class, function code and operand fields.
// Because the decode reads only the registered head entry, there is no
// combinational path from inst_i to any field output.
//
// Ports
//   clk          single clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   cen          clock enable; 0 holds all state and blocks transfers
//   flush_i      discard every queued instruction (taken branch/jump)
//   in_valid_i   inst_i carries an instruction to enqueue
//   inst_i       raw 18-bit instruction word
//   in_ready_o   queue accepts an instruction this cycle
//   out_valid_o  decoded head instruction is valid
//   out_ready_i  consumer takes the head instruction this cycle
//   class_o      0 ALU-immed, 1 ALU-reg, 2 shift, 3 mem, 4 branch,
//                5 jump, 6 misc, 7 illegal
//   op_o         inst[17:11] of the head
//   func_o       function code of the head
//   addr_o       inst[11:0]
//   disp_o       inst[7:0]
//   immed_o      inst[7:0]
//   rs_o         inst[10:8]
//   rs2_o        inst[7:5]
//   rd_o         inst[13:11]
//   count_o      inst[7:5]
//   level_o      number of queued instructions, 0..DEPTH
//
// Every field output and class_o reads 0 while out_valid_o is 0.

module ir_queue #(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [17:0]      inst_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [2:0]       class_o,
  output logic [6:0]       op_o,
  output logic [2:0]       func_o,
  output logic [11:0]      addr_o,
  output logic [7:0]       disp_o,
  output logic [7:0]       immed_o,
  output logic [2:0]       rs_o,
  output logic [2:0]       rs2_o,
  output logic [2:0]       rd_o,
  output logic [2:0]       count_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [17:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             not_full;
  logic             not_empty;
  logic             push;
  logic             pop;
  logic [17:0]      head;

  assign not_full  = (level != FULL_LVL);
  assign not_empty = (level != '0);

  // A full queue refuses a push even when a pop happens in the same cycle,
  // so in_ready_o never depends on out_ready_i.
  assign in_ready_o  = cen & ~rst & not_full;
  assign out_valid_o = cen & not_empty;

  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i & ~flush_i;

  assign level_o = level;

  // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (cen) begin
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   level <= level + LVL_W'(1);
          2'b01:   level <= level - LVL_W'(1);
          default: level <= level;
        endcase
      end
    end
  end

  // Storage is not reset; reset and flush only move the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= inst_i;
  end

  assign head = mem[rd_ptr];

  always_comb begin
    class_o = 3'd0;
    func_o  = 3'd0;
    op_o    = 7'd0;
    addr_o  = 12'd0;
    disp_o  = 8'd0;
    immed_o = 8'd0;
    rs_o    = 3'd0;
    rs2_o   = 3'd0;
    rd_o    = 3'd0;
    count_o = 3'd0;
    if (out_valid_o) begin
      op_o    = head[17:11];
      addr_o  = head[11:0];
      disp_o  = head[7:0];
      immed_o = head[7:0];
      rs_o    = head[10:8];
      rs2_o   = head[7:5];
      rd_o    = head[13:11];
      count_o = head[7:5];
      // Opcode prefixes grow one leading 1 per class; first match wins.
      if (!head[17]) begin
        class_o = 3'd0;
        func_o  = head[16:14];
      end else if (head[17:16] == 2'b10) begin
        class_o = 3'd3;
        func_o  = {1'b0, head[15:14]};
      end else if (head[17:15] == 3'b110) begin
        class_o = 3'd2;
        func_o  = head[2:0];
      end else if (head[17:14] == 4'b1110) begin
        class_o = 3'd1;
        func_o  = head[2:0];
      end else if (head[17:13] == 5'b11110) begin
        class_o = 3'd5;
        func_o  = {2'b00, head[12]};
      end else if (head[17:12] == 6'b111110) begin
        class_o = 3'd4;
        func_o  = {1'b0, head[11:10]};
      end else if (head[17:11] == 7'b1111110) begin
        class_o = 3'd6;
        func_o  = head[10:8];
      end else begin
        class_o = 3'd7;
        func_o  = 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_ir_queue.sv
// tb_ir_queue -- self-checking bench for ir_queue (DEPTH = 4).
// A queue-based reference model predicts every output each cycle; directed
// sequences and a decode table cover the corner cases, then random traffic.

module tb_ir_queue;

  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             cen;
  logic             flush_i;
  logic             in_valid_i;
  logic [17:0]      inst_i;
  logic             in_ready_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [2:0]       class_o;
  logic [6:0]       op_o;
  logic [2:0]       func_o;
  logic [11:0]      addr_o;
  logic [7:0]       disp_o;
  logic [7:0]       immed_o;
  logic [2:0]       rs_o;
  logic [2:0]       rs2_o;
  logic [2:0]       rd_o;
  logic [2:0]       count_o;
  logic [LVL_W-1:0] level_o;

  ir_queue #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clk(clk), .rst(rst), .cen(cen), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .inst_i(inst_i), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .class_o(class_o), .op_o(op_o), .func_o(func_o), .addr_o(addr_o),
    .disp_o(disp_o), .immed_o(immed_o), .rs_o(rs_o), .rs2_o(rs2_o),
    .rd_o(rd_o), .count_o(count_o), .level_o(level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [17:0] q[$];

  typedef struct {
    logic [17:0] inst;
    logic [2:0]  cls;
    logic [2:0]  fn;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Class is determined by how many leading ones the 7-bit opcode field has.
  function automatic logic [5:0] ref_decode(input logic [17:0] h);
    int n;
    logic [2:0] c;
    logic [2:0] f;
    n = 0;
    for (int k = 0; k < 7; k++)
      if (n == k && h[17-k]) n = k + 1;
    case (n)
      0: begin c = 3'd0; f = h[16:14]; end
      1: begin c = 3'd3; f = {1'b0, h[15:14]}; end
      2: begin c = 3'd2; f = h[2:0]; end
      3: begin c = 3'd1; f = h[2:0]; end
      4: begin c = 3'd5; f = {2'b00, h[12]}; end
      5: begin c = 3'd4; f = {1'b0, h[11:10]}; end
      6: begin c = 3'd6; f = h[10:8]; end
      default: begin c = 3'd7; f = 3'd0; end
    endcase
    return {c, f};
  endfunction

  task automatic check_outputs();
    logic        ev;
    logic [17:0] h;
    logic [5:0]  cf;
    ev = cen && (q.size() > 0);
    h  = ev ? q[0] : 18'd0;
    cf = ev ? ref_decode(h) : 6'd0;
    chk("in_ready", 32'(in_ready_o), 32'(cen && !rst && (q.size() < DEPTH)));
    chk("out_valid", 32'(out_valid_o), 32'(ev));
    chk("level", 32'(level_o), 32'(q.size()));
    chk("class", 32'(class_o), 32'(cf[5:3]));
    chk("func", 32'(func_o), 32'(cf[2:0]));
    chk("op", 32'(op_o), 32'(h[17:11]));
    chk("addr", 32'(addr_o), 32'(h[11:0]));
    chk("disp", 32'(disp_o), 32'(h[7:0]));
    chk("immed", 32'(immed_o), 32'(h[7:0]));
    chk("rs", 32'(rs_o), 32'(h[10:8]));
    chk("rs2", 32'(rs2_o), 32'(h[7:5]));
    chk("rd", 32'(rd_o), 32'(h[13:11]));
    chk("count", 32'(count_o), 32'(h[7:5]));
  endtask

  task automatic model_update();
    bit do_push;
    bit do_pop;
    if (rst) begin
      q.delete();
    end else if (cen) begin
      if (flush_i) begin
        q.delete();
      end else begin
        do_push = in_valid_i && (q.size() < DEPTH);
        do_pop  = out_ready_i && (q.size() > 0);
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(inst_i);
      end
    end
  endtask

  task automatic cycle(input bit c, input bit r, input bit f, input bit v,
                       input logic [17:0] w, input bit o);
    cen = c; rst = r; flush_i = f; in_valid_i = v; inst_i = w; out_ready_i = o;
    @(negedge clk);
    if (chk_en) check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic push_word(input logic [17:0] w);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, w, 1'b0);
  endtask

  task automatic pop_word();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 18'd0, 1'b1);
  endtask

  initial begin
    tbl[0] = '{18'h04A05, 3'd0, 3'd1};
    tbl[1] = '{18'h38005, 3'd1, 3'd5};
    tbl[2] = '{18'h30003, 3'd2, 3'd3};
    tbl[3] = '{18'h2C000, 3'd3, 3'd3};
    tbl[4] = '{18'h3E8A5, 3'd4, 3'd2};
    tbl[5] = '{18'h3EC00, 3'd4, 3'd3};
    tbl[6] = '{18'h3D000, 3'd5, 3'd1};
    tbl[7] = '{18'h3F500, 3'd6, 3'd5};
    tbl[8] = '{18'h3FFFF, 3'd7, 3'd0};
    tbl[9] = '{18'h3F800, 3'd7, 3'd0};

    // Reset; the very first edge establishes state so it is not checked.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 18'd0, 1'b0);
    chk_en = 1'b1;
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 18'h12345, 1'b1);
    chk("rst_level", 32'(level_o), 0);
    chk("rst_valid", 32'(out_valid_o), 0);

    // Single ALU-immed word, visible one cycle after the push.
    push_word(18'h04A05);
    chk("alu_valid", 32'(out_valid_o), 1);
    chk("alu_class", 32'(class_o), 0);
    chk("alu_func", 32'(func_o), 1);
    chk("alu_rs", 32'(rs_o), 2);
    chk("alu_rd", 32'(rd_o), 1);
    chk("alu_immed", 32'(immed_o), 5);
    chk("alu_level", 32'(level_o), 1);
    pop_word();

    // Fill to full, hold a refused push, then drain in order.
    for (int i = 1; i <= DEPTH; i++) push_word(18'(32'h10000 + i));
    chk("full_level", 32'(level_o), DEPTH);
    chk("full_ready", 32'(in_ready_o), 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 18'h15555, 1'b0);
    chk("full_hold", 32'(level_o), DEPTH);
    for (int i = 1; i <= DEPTH; i++) begin
      chk("drain_order", 32'(immed_o), i);
      cycle(1'b1, 1'b0, 1'b0, (i == 1), 18'h15555, 1'b1);
    end
    chk("drain_level", 32'(level_o), 0);
    chk("drain_valid", 32'(out_valid_o), 0);

    // Steady push+pop at level 2 wraps the pointers.
    push_word(18'h00100);
    push_word(18'h00101);
    for (int i = 2; i < 12; i++) begin
      chk("wrap_order", 32'(immed_o), i - 2);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 18'(32'h00100 + i), 1'b1);
      chk("wrap_level", 32'(level_o), 2);
    end
    pop_word();
    pop_word();

    // Flush with a concurrent push and pop.
    for (int i = 0; i < 3; i++) push_word(18'(32'h20010 + i));
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 18'h2ABCD, 1'b1);
    chk("flush_level", 32'(level_o), 0);
    chk("flush_valid", 32'(out_valid_o), 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 18'd0, 1'b1);
    chk("flush_absent", 32'(level_o), 0);

    // Clock enable low holds everything; flush and reset while disabled.
    push_word(18'h0AA11);
    push_word(18'h0AA22);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, (i == 2), 1'b1, 18'h0BB33, 1'b1);
      chk("cen_level", 32'(level_o), 2);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 18'h0BB44, 1'b1);
    chk("cen_rst_level", 32'(level_o), 0);

    // Decode table, one word per class.
    for (int i = 0; i < 10; i++) begin
      push_word(tbl[i].inst);
      chk("tbl_class", 32'(class_o), 32'(tbl[i].cls));
      chk("tbl_func", 32'(func_o), 32'(tbl[i].fn));
      pop_word();
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 99) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6,
            18'($urandom), $urandom_range(0, 9) < 6);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
